// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: sequences decoded instructions through the register-file
// lookup, holds the returned operands while snooping ROB commits, and
// dispatches each instruction once to the RS or the SLB.
// Optional build macro: DISPATCH_PERF_EN (adds stall/dispatch counters).
module dispatch_ctrl #(
    parameter int PcLength     = 31,
    parameter int DataLength   = 31,
    parameter int RegIdxLength = 4,
    parameter int OpLength     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  valid_from_decoder,
    output logic                  ready_to_decoder,
    input  logic [PcLength:0]     pc_from_decoder,
    input  logic [OpLength:0]     op_from_decoder,
    input  logic                  is_ls_from_decoder,
    input  logic [RegIdxLength:0] rd_from_decoder,
    input  logic [RegIdxLength:0] rs1_from_decoder,
    input  logic [RegIdxLength:0] rs2_from_decoder,
    output logic                  is_empty_to_rf,
    output logic [RegIdxLength:0] rd_to_rf,
    output logic [RegIdxLength:0] rs1_to_rf,
    output logic [RegIdxLength:0] rs2_to_rf,
    output logic [PcLength:0]     pc_to_rf,
    input  logic [DataLength:0]   v1_from_rf,
    input  logic [DataLength:0]   v2_from_rf,
    input  logic [PcLength:0]     q1_from_rf,
    input  logic [PcLength:0]     q2_from_rf,
    input  logic                  rob_full,
    input  logic                  rs_full,
    input  logic                  slb_full,
    output logic                  en_to_rob,
    input  logic                  is_commit_from_rob,
    input  logic [PcLength:0]     pc_from_rob,
    input  logic [DataLength:0]   data_from_rob,
    input  logic                  is_exception_from_rob,
    output logic                  en_to_rs,
    output logic                  en_to_slb,
    output logic [OpLength:0]     op_out,
    output logic [PcLength:0]     pc_out,
    output logic [DataLength:0]   v1_out,
    output logic [DataLength:0]   v2_out,
    output logic [PcLength:0]     q1_out,
    output logic [PcLength:0]     q2_out
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           dispatched
`endif
);

    typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [OpLength:0]     op_reg, op_next;
    logic [PcLength:0]     pc_reg, pc_next;
    logic                  is_ls_reg, is_ls_next;
    logic [DataLength:0]   v1_reg, v1_next, v2_reg, v2_next;
    logic [PcLength:0]     q1_reg, q1_next, q2_reg, q2_next;

    logic                  active;
    logic                  fire;
    logic                  accept;
    logic                  hit1_hold, hit2_hold, hit1_rf, hit2_rf;
    logic [DataLength:0]   s_v1, s_v2, c_v1, c_v2;
    logic [PcLength:0]     s_q1, s_q2, c_q1, c_q2;

    // A commit broadcast resolves an operand only when the tag is pending (non-zero) and matches.
    function automatic logic snoop_hit(input logic commit, input logic [PcLength:0] q,
                                       input logic [PcLength:0] rob_pc);
        return commit && (q != '0) && (q == rob_pc);
    endfunction

    // Snooped operand views: hold registers (HOLD) and raw register-file outputs (CAPT).
    always_comb begin
        hit1_hold = snoop_hit(is_commit_from_rob, q1_reg, pc_from_rob);
        hit2_hold = snoop_hit(is_commit_from_rob, q2_reg, pc_from_rob);
        hit1_rf   = snoop_hit(is_commit_from_rob, q1_from_rf, pc_from_rob);
        hit2_rf   = snoop_hit(is_commit_from_rob, q2_from_rf, pc_from_rob);
        s_v1 = hit1_hold ? data_from_rob : v1_reg;
        s_q1 = hit1_hold ? '0 : q1_reg;
        s_v2 = hit2_hold ? data_from_rob : v2_reg;
        s_q2 = hit2_hold ? '0 : q2_reg;
        c_v1 = hit1_rf ? data_from_rob : v1_from_rf;
        c_q1 = hit1_rf ? '0 : q1_from_rf;
        c_v2 = hit2_rf ? data_from_rob : v2_from_rf;
        c_q2 = hit2_rf ? '0 : q2_from_rf;
    end

    // Next-state, handshake and dispatch outputs; reset, rdy=0 and exception all quiesce the outputs.
    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        pc_next          = pc_reg;
        is_ls_next       = is_ls_reg;
        v1_next          = v1_reg;
        v2_next          = v2_reg;
        q1_next          = q1_reg;
        q2_next          = q2_reg;
        is_empty_to_rf   = 1'b1;
        en_to_rob        = 1'b0;
        rd_to_rf         = '0;
        rs1_to_rf        = '0;
        rs2_to_rf        = '0;
        pc_to_rf         = '0;
        en_to_rs         = 1'b0;
        en_to_slb        = 1'b0;
        op_out           = '0;
        pc_out           = '0;
        v1_out           = '0;
        v2_out           = '0;
        q1_out           = '0;
        q2_out           = '0;

        active           = rst && rdy && !is_exception_from_rob;
        fire             = active && (state_reg == HOLD) && (is_ls_reg ? !slb_full : !rs_full);
        ready_to_decoder = active && !rob_full && ((state_reg == IDLE) || fire);
        accept           = valid_from_decoder && ready_to_decoder;

        if (accept) begin
            is_empty_to_rf = 1'b0;
            en_to_rob      = 1'b1;
            rd_to_rf       = rd_from_decoder;
            rs1_to_rf      = rs1_from_decoder;
            rs2_to_rf      = rs2_from_decoder;
            pc_to_rf       = pc_from_decoder;
            op_next        = op_from_decoder;
            pc_next        = pc_from_decoder;
            is_ls_next     = is_ls_from_decoder;
        end

        if (active) begin
            case (state_reg)
                IDLE: begin
                    if (accept) state_next = CAPT;
                end
                CAPT: begin
                    v1_next    = c_v1;
                    q1_next    = c_q1;
                    v2_next    = c_v2;
                    q2_next    = c_q2;
                    state_next = HOLD;
                end
                HOLD: begin
                    v1_next = s_v1;
                    q1_next = s_q1;
                    v2_next = s_v2;
                    q2_next = s_q2;
                    if (fire) begin
                        en_to_slb  = is_ls_reg;
                        en_to_rs   = !is_ls_reg;
                        op_out     = op_reg;
                        pc_out     = pc_reg;
                        v1_out     = s_v1;
                        q1_out     = s_q1;
                        v2_out     = s_v2;
                        q2_out     = s_q2;
                        state_next = accept ? CAPT : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (rst && rdy && is_exception_from_rob) begin
            state_next = IDLE;
            op_next    = '0;
            pc_next    = '0;
            is_ls_next = 1'b0;
            v1_next    = '0;
            v2_next    = '0;
            q1_next    = '0;
            q2_next    = '0;
        end
    end

    // State and hold registers; rdy=0 leaves every _next equal to its register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            pc_reg    <= '0;
            is_ls_reg <= 1'b0;
            v1_reg    <= '0;
            v2_reg    <= '0;
            q1_reg    <= '0;
            q2_reg    <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            pc_reg    <= pc_next;
            is_ls_reg <= is_ls_next;
            v1_reg    <= v1_next;
            v2_reg    <= v2_next;
            q1_reg    <= q1_next;
            q2_reg    <= q2_next;
        end
    end

`ifdef DISPATCH_PERF_EN
    // Free-running performance counters; exceptions do not clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            dispatched   <= '0;
        end else begin
            if (rdy && (state_reg == HOLD) && !fire) stall_cycles <= stall_cycles + 32'd1;
            if (en_to_rs || en_to_slb) dispatched <= dispatched + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed testbench for dispatch_ctrl: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        valid_from_decoder, ready_to_decoder;
    logic [31:0] pc_from_decoder;
    logic [5:0]  op_from_decoder;
    logic        is_ls_from_decoder;
    logic [4:0]  rd_from_decoder, rs1_from_decoder, rs2_from_decoder;
    logic        is_empty_to_rf;
    logic [4:0]  rd_to_rf, rs1_to_rf, rs2_to_rf;
    logic [31:0] pc_to_rf;
    logic [31:0] v1_from_rf, v2_from_rf, q1_from_rf, q2_from_rf;
    logic        rob_full, rs_full, slb_full, en_to_rob;
    logic        is_commit_from_rob;
    logic [31:0] pc_from_rob, data_from_rob;
    logic        is_exception_from_rob;
    logic        en_to_rs, en_to_slb;
    logic [5:0]  op_out;
    logic [31:0] pc_out, v1_out, v2_out, q1_out, q2_out;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    dispatch_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .valid_from_decoder(valid_from_decoder), .ready_to_decoder(ready_to_decoder),
        .pc_from_decoder(pc_from_decoder), .op_from_decoder(op_from_decoder),
        .is_ls_from_decoder(is_ls_from_decoder), .rd_from_decoder(rd_from_decoder),
        .rs1_from_decoder(rs1_from_decoder), .rs2_from_decoder(rs2_from_decoder),
        .is_empty_to_rf(is_empty_to_rf), .rd_to_rf(rd_to_rf), .rs1_to_rf(rs1_to_rf),
        .rs2_to_rf(rs2_to_rf), .pc_to_rf(pc_to_rf),
        .v1_from_rf(v1_from_rf), .v2_from_rf(v2_from_rf),
        .q1_from_rf(q1_from_rf), .q2_from_rf(q2_from_rf),
        .rob_full(rob_full), .rs_full(rs_full), .slb_full(slb_full), .en_to_rob(en_to_rob),
        .is_commit_from_rob(is_commit_from_rob), .pc_from_rob(pc_from_rob),
        .data_from_rob(data_from_rob), .is_exception_from_rob(is_exception_from_rob),
        .en_to_rs(en_to_rs), .en_to_slb(en_to_slb), .op_out(op_out), .pc_out(pc_out),
        .v1_out(v1_out), .v2_out(v2_out), .q1_out(q1_out), .q2_out(q2_out)
    );

    // 10ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic v, input logic [31:0] pc, input logic [5:0] op, input logic ls);
        valid_from_decoder = v;
        pc_from_decoder    = pc;
        op_from_decoder    = op;
        is_ls_from_decoder = ls;
        rd_from_decoder    = 5'd1;
        rs1_from_decoder   = 5'd3;
        rs2_from_decoder   = 5'd4;
    endtask

    task automatic rf(input logic [31:0] v1, input logic [31:0] q1,
                      input logic [31:0] v2, input logic [31:0] q2);
        v1_from_rf = v1; q1_from_rf = q1; v2_from_rf = v2; q2_from_rf = q2;
    endtask

    task automatic cmt(input logic en, input logic [31:0] pc, input logic [31:0] d);
        is_commit_from_rob = en; pc_from_rob = pc; data_from_rob = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        dec(1'b1, 32'h100, 6'd5, 1'b0);
        rf(32'h0, 32'h0, 32'h0, 32'h0);
        cmt(1'b0, 32'h0, 32'h0);
        rob_full = 1'b0; rs_full = 1'b0; slb_full = 1'b0; is_exception_from_rob = 1'b0;

        // Reset values while a valid instruction is presented.
        #2;
        chk("rst_ready", ready_to_decoder, 0);
        chk("rst_empty", is_empty_to_rf, 1);
        chk("rst_en_rob", en_to_rob, 0);
        chk("rst_rs1_to_rf", rs1_to_rf, 0);
        chk("rst_en_rs", en_to_rs, 0);
        chk("rst_pc_out", pc_out, 0);
        tick(); rst = 1'b1; dec(1'b0, 0, 0, 0);

        // rob_full blocks acceptance in IDLE.
        tick(); rob_full = 1'b1; dec(1'b1, 32'h100, 6'd5, 1'b0); settle();
        chk("robfull_ready", ready_to_decoder, 0);
        chk("robfull_empty", is_empty_to_rf, 1);

        // Basic ALU dispatch: accept at t, dispatch to RS at t+2.
        tick(); rob_full = 1'b0; settle();
        chk("alu_ready", ready_to_decoder, 1);
        chk("alu_empty_t", is_empty_to_rf, 0);
        chk("alu_en_rob", en_to_rob, 1);
        chk("alu_rs1_to_rf", rs1_to_rf, 3);
        chk("alu_pc_to_rf", pc_to_rf, 32'h100);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h7, 32'h0, 32'h9, 32'h0); settle();
        chk("alu_empty_t1", is_empty_to_rf, 1);
        chk("alu_en_rob_t1", en_to_rob, 0);
        chk("alu_ready_t1", ready_to_decoder, 0);
        chk("alu_en_rs_t1", en_to_rs, 0);
        tick(); rf(32'h55, 32'h55, 32'h55, 32'h55); settle();
        chk("alu_en_rs", en_to_rs, 1);
        chk("alu_en_slb", en_to_slb, 0);
        chk("alu_v1", v1_out, 32'h7);
        chk("alu_q1", q1_out, 32'h0);
        chk("alu_v2", v2_out, 32'h9);
        chk("alu_pc", pc_out, 32'h100);
        chk("alu_op", op_out, 6'd5);
        tick(); settle();
        chk("alu_en_rs_after", en_to_rs, 0);
        chk("alu_v1_after", v1_out, 0);

        // Load held by slb_full for 5 cycles, then dispatched to SLB.
        dec(1'b1, 32'h200, 6'd9, 1'b1);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h11, 32'h0, 32'h22, 32'h0);
        tick(); slb_full = 1'b1; dec(1'b1, 32'h204, 6'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("ld_stall_en_slb", en_to_slb, 0);
            chk("ld_stall_ready", ready_to_decoder, 0);
            chk("ld_stall_empty", is_empty_to_rf, 1);
            tick();
        end
        slb_full = 1'b0; dec(1'b0, 0, 0, 0); settle();
        chk("ld_en_slb", en_to_slb, 1);
        chk("ld_en_rs", en_to_rs, 0);
        chk("ld_v1", v1_out, 32'h11);
        chk("ld_v2", v2_out, 32'h22);
        chk("ld_pc", pc_out, 32'h200);

        // Commit snooped during a HOLD stall.
        tick(); dec(1'b1, 32'h300, 6'd2, 1'b0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h3, 32'h0, 32'h1, 32'h40); rs_full = 1'b1;
        tick(); cmt(1'b1, 32'h40, 32'hDEAD); settle();
        chk("snh_en_rs_stall", en_to_rs, 0);
        tick(); cmt(1'b0, 32'h0, 32'h0); rs_full = 1'b0; settle();
        chk("snh_en_rs", en_to_rs, 1);
        chk("snh_v2", v2_out, 32'hDEAD);
        chk("snh_q2", q2_out, 32'h0);
        chk("snh_v1", v1_out, 32'h3);

        // Commit snooped in the CAPT cycle.
        tick(); dec(1'b1, 32'h310, 6'd2, 1'b0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h0, 32'h0, 32'h1, 32'h40); cmt(1'b1, 32'h40, 32'hDEAD);
        tick(); cmt(1'b0, 32'h0, 32'h0); settle();
        chk("snc_en_rs", en_to_rs, 1);
        chk("snc_v2", v2_out, 32'hDEAD);
        chk("snc_q2", q2_out, 32'h0);

        // Commit in the fire cycle itself; a non-matching tag stays pending.
        tick(); dec(1'b1, 32'h320, 6'd2, 1'b0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h2, 32'h50, 32'h6, 32'h60);
        tick(); cmt(1'b1, 32'h50, 32'hBEEF); settle();
        chk("snf_v1", v1_out, 32'hBEEF);
        chk("snf_q1", q1_out, 32'h0);
        chk("snf_v2", v2_out, 32'h6);
        chk("snf_q2", q2_out, 32'h60);

        // Back-to-back: accept at t and t+2, dispatches at t+2 and t+4.
        tick(); cmt(1'b0, 0, 0); dec(1'b1, 32'h400, 6'd3, 1'b0); settle();
        chk("b2b_empty_t", is_empty_to_rf, 0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h0, 32'h0, 32'h0, 32'h0);
        tick(); dec(1'b1, 32'h404, 6'd4, 1'b0); settle();
        chk("b2b_en_rs_t2", en_to_rs, 1);
        chk("b2b_pc_t2", pc_out, 32'h400);
        chk("b2b_op_t2", op_out, 6'd3);
        chk("b2b_ready_t2", ready_to_decoder, 1);
        chk("b2b_empty_t2", is_empty_to_rf, 0);
        chk("b2b_pc_to_rf_t2", pc_to_rf, 32'h404);
        tick(); dec(1'b0, 0, 0, 0); rf(32'hA, 32'h0, 32'h0, 32'h0); settle();
        chk("b2b_empty_t3", is_empty_to_rf, 1);
        chk("b2b_en_rs_t3", en_to_rs, 0);
        tick(); settle();
        chk("b2b_en_rs_t4", en_to_rs, 1);
        chk("b2b_pc_t4", pc_out, 32'h404);
        chk("b2b_v1_t4", v1_out, 32'hA);

        // Exception while held with rs_full=1.
        tick(); dec(1'b1, 32'h500, 6'd7, 1'b0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h5, 32'h0, 32'h0, 32'h0); rs_full = 1'b1;
        tick(); settle();
        chk("exc_hold_en_rs", en_to_rs, 0);
        tick(); is_exception_from_rob = 1'b1; rs_full = 1'b0; dec(1'b1, 32'h5FF, 6'd7, 1'b0); settle();
        chk("exc_en_rs", en_to_rs, 0);
        chk("exc_ready", ready_to_decoder, 0);
        chk("exc_empty", is_empty_to_rf, 1);
        chk("exc_en_rob", en_to_rob, 0);
        tick(); is_exception_from_rob = 1'b0; dec(1'b0, 0, 0, 0); settle();
        chk("exc_after_en_rs", en_to_rs, 0);
        chk("exc_after_ready", ready_to_decoder, 1);
        tick(); dec(1'b1, 32'h600, 6'd8, 1'b0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h66, 32'h0, 32'h0, 32'h0);
        tick(); settle();
        chk("exc_next_en_rs", en_to_rs, 1);
        chk("exc_next_pc", pc_out, 32'h600);
        chk("exc_next_v1", v1_out, 32'h66);

        // Asynchronous reset pulsed between edges while in CAPT.
        tick(); dec(1'b1, 32'h700, 6'd1, 1'b0);
        tick(); dec(1'b1, 32'h704, 6'd1, 1'b0); rf(32'h77, 32'h0, 32'h0, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("arst_ready", ready_to_decoder, 0);
        chk("arst_empty", is_empty_to_rf, 1);
        chk("arst_en_rob", en_to_rob, 0);
        rst = 1'b1; dec(1'b0, 0, 0, 0);
        #1;
        chk("arst_idle_ready", ready_to_decoder, 1);
        tick(); settle();
        chk("arst_no_dispatch", en_to_rs, 0);

        // rdy=0 for 3 cycles in HOLD freezes everything.
        tick(); dec(1'b1, 32'h800, 6'd2, 1'b0);
        tick(); dec(1'b0, 0, 0, 0); rf(32'h33, 32'h0, 32'h0, 32'h0);
        tick(); rdy = 1'b0; dec(1'b1, 32'h804, 6'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rdy0_en_rs", en_to_rs, 0);
            chk("rdy0_empty", is_empty_to_rf, 1);
            chk("rdy0_ready", ready_to_decoder, 0);
            tick();
        end
        rdy = 1'b1; dec(1'b0, 0, 0, 0); settle();
        chk("rdy1_en_rs", en_to_rs, 1);
        chk("rdy1_pc", pc_out, 32'h800);
        chk("rdy1_v1", v1_out, 32'h33);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sequences decoded instructions into the register-file rename/lookup port.
- Captures the operand values and tags the register file returns, and keeps them current by snooping ROB commits while held.
- Dispatches each instruction exactly once to the reservation station (RS) or the store/load buffer (SLB), with full-flag backpressure and exception flush.
- Sits between the decoder and the register file, RS, SLB and ROB allocation.

Parameters:
- PcLength, 31, MSB index of pc/tag buses (tag 0 = "value ready")
- DataLength, 31, MSB index of data buses
- RegIdxLength, 4, MSB index of register indices
- OpLength, 5, MSB index of opcode bus

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low = freeze
- valid_from_decoder  in  1  decoded instruction valid
- ready_to_decoder  out  1  accept this cycle (handshake = valid & ready)
- pc_from_decoder  in  PcLength+1  instruction pc / ROB tag
- op_from_decoder  in  OpLength+1  opcode
- is_ls_from_decoder  in  1  1 = load/store, route to SLB
- rd_from_decoder, rs1_from_decoder, rs2_from_decoder  in  RegIdxLength+1 each  register indices
- is_empty_to_rf  out  1  0 = register-file lookup/rename this cycle
- rd_to_rf, rs1_to_rf, rs2_to_rf  out  RegIdxLength+1 each  indices to the register file
- pc_to_rf  out  PcLength+1  tag to the register file
- v1_from_rf, v2_from_rf  in  DataLength+1  operand values
- q1_from_rf, q2_from_rf  in  PcLength+1  operand tags
- rob_full, rs_full, slb_full  in  1 each  capacity flags
- en_to_rob  out  1  ROB allocate pulse
- is_commit_from_rob  in  1  commit broadcast valid
- pc_from_rob  in  PcLength+1  committing tag
- data_from_rob  in  DataLength+1  committing data
- is_exception_from_rob  in  1  flush
- en_to_rs, en_to_slb  out  1 each  dispatch pulse
- op_out  out  OpLength+1  dispatched opcode
- pc_out  out  PcLength+1  dispatched tag
- v1_out, v2_out  out  DataLength+1  dispatched values
- q1_out, q2_out  out  PcLength+1  dispatched tags

Behaviour:
- Reset (rst=0, async):
  - state IDLE; all hold registers 0.
  - Outputs: is_empty_to_rf=1, en_to_rob=0, en_to_rs=0, en_to_slb=0, ready_to_decoder=0; all buses 0.
- FSM states: IDLE, CAPT, HOLD.
- ready_to_decoder = rdy & !is_exception_from_rob & !rob_full & (state==IDLE | (state==HOLD & dispatch_fire)). Combinational.
- Accept (valid & ready):
  - is_empty_to_rf=0 and en_to_rob=1 in the same cycle, for exactly one cycle.
  - rd/rs1/rs2/pc driven combinationally from the decoder inputs.
  - Latch op, pc, is_ls; next state CAPT.
  - is_empty_to_rf must never be 0 for more than one cycle per instruction, because the register file re-renames on every non-empty cycle.
- CAPT:
  - Register-file outputs are valid this cycle; latch v1/v2/q1/q2 into hold registers; next state HOLD.
- Commit snoop (CAPT and HOLD):
  - If is_commit_from_rob & qN!=0 & qN==pc_from_rob, then vN<=data_from_rob and qN<=0.
  - In CAPT, qN is the incoming register-file tag.
- HOLD:
  - dispatch_fire = is_ls ? !slb_full : !rs_full.
  - On fire: one-cycle pulse on en_to_slb or en_to_rs; *_out driven from the hold registers with the same-cycle snoop applied combinationally.
  - On fire, next state is CAPT if a new accept happened in the same cycle, else IDLE.
  - Without fire, stay in HOLD indefinitely; snoop continues.
- Latency: accept at cycle t, earliest dispatch at t+2. Peak throughput 1 instruction per 2 cycles (back-to-back accept in the HOLD fire cycle).
- Exception (is_exception_from_rob=1):
  - Takes priority over everything.
  - Force IDLE, clear hold registers; no en_* pulse, no accept, is_empty_to_rf=1 that cycle.
- rdy=0: state and registers frozen; is_empty_to_rf=1, en_* = 0, ready=0. Exception is not sampled.
- *_out are 0 when no en_* pulse is asserted.

Optional Feature:
- Macro: DISPATCH_PERF_EN.
- Defined:
  - Adds output stall_cycles (32b) and output dispatched (32b), both reset to 0.
  - stall_cycles increments on every rdy cycle in HOLD without fire.
  - dispatched increments on every en_to_rs or en_to_slb pulse.
  - Both wrap at 2^32 and are not cleared by exception.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Basic ALU dispatch: pc=0x100, rs1=3 (q=0, v=7), rs_full=0 -> is_empty_to_rf=0 for 1 cycle at t; en_to_rs=1 at t+2 with v1_out=7, q1_out=0, pc_out=0x100.
- Load to SLB: is_ls=1, slb_full=1 for 5 cycles -> held in HOLD, no pulse for 5 cycles, ready_to_decoder=0; en_to_slb on the cycle slb_full drops.
- Snoop during stall: q2_from_rf=0x40, commit pc=0x40 data=0xDEAD in HOLD -> dispatch shows v2_out=0xDEAD, q2_out=0. Repeat with the commit in the CAPT cycle -> same result.
- Back-to-back issue: two valid instructions, both targets free -> en pulses at t+2 and t+4; is_empty_to_rf low exactly at t and t+2.
- Exception in HOLD with rs_full=1 -> no en_to_rs ever, state IDLE next cycle; next instruction dispatches normally.
- Async reset asserted mid-CAPT (between clock edges) -> outputs immediately at reset values. rdy=0 for 3 cycles in HOLD -> no pulse, dispatch resumes after rdy returns.
